mp_regfile: RTL and testbench



---
 rtl/mp_regfile.sv | 107 ++++++++++
 tb/tb_mp_regfile.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_regfile.sv
// mp_regfile -- multi-ported register file with a per-register busy scoreboard.
//
// Ports:
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset; clears registers, busy bits, busy_cnt
//   ra        NRD read addresses, port i at [i*AW +: AW]
//   rd        NRD read data words, combinational
//   rd_busy   per read port: the addressed register has an outstanding producer
//   we/wa/wd  NWR write ports; a higher port index is a younger issue slot
//   iss_en    per issue slot: mark iss_addr busy at the next edge
//   iss_addr  NWR issued destination addresses
//   busy_cnt  registered popcount of the busy bits (0..NREG)
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports, and to mask rd_busy for registers being written this cycle.
//
// Addresses >= NREG are inert: writes and issues are ignored, reads return 0.
// With ZERO_R0 set, register 0 is inert in the same way (it never has a producer).
module mp_regfile #(
   parameter int DATA_W  = 32,
   parameter int NREG    = 32,
   parameter int NRD     = 4,
   parameter int NWR     = 2,
   parameter int ZERO_R0 = 1,
   localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1,
   localparam int CW     = $clog2(NREG) + 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [NRD*AW-1:0]     ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic [NRD-1:0]        rd_busy,
   input  logic [NWR-1:0]        we,
   input  logic [NWR*AW-1:0]     wa,
   input  logic [NWR*DATA_W-1:0] wd,
   input  logic [NWR-1:0]        iss_en,
   input  logic [NWR*AW-1:0]     iss_addr,
   output logic [CW-1:0]         busy_cnt
);

   logic [DATA_W-1:0] rf [NREG];
   logic [NREG-1:0]   busy;
   logic [NREG-1:0]   busy_nxt;
   logic [CW-1:0]     cnt_nxt;

   // True when the address names a real, writable register.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      addr_ok = (32'(a) < 32'(NREG)) && !((ZERO_R0 != 0) && (a == '0));
   endfunction

   // Ports are visited in ascending order, so the youngest enabled port
   // to the same address is the last non-blocking assignment and wins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rf <= '{default: '0};
      end else begin
         for (int unsigned j = 0; j < NWR; j++) begin
            if (we[j] && addr_ok(wa[j*AW +: AW]))
               rf[wa[j*AW +: AW]] <= wd[j*DATA_W +: DATA_W];
         end
      end
   end

   // Clears applied first, sets second: a new producer overrides a retiring one.
   always_comb begin
      busy_nxt = busy;
      for (int unsigned j = 0; j < NWR; j++) begin
         if (we[j] && addr_ok(wa[j*AW +: AW]))
            busy_nxt[wa[j*AW +: AW]] = 1'b0;
      end
      for (int unsigned j = 0; j < NWR; j++) begin
         if (iss_en[j] && addr_ok(iss_addr[j*AW +: AW]))
            busy_nxt[iss_addr[j*AW +: AW]] = 1'b1;
      end
      cnt_nxt = CW'($countones(busy_nxt));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      rd      = '0;
      rd_busy = '0;
      for (int unsigned i = 0; i < NRD; i++) begin
         if (addr_ok(ra[i*AW +: AW])) begin
            rd[i*DATA_W +: DATA_W] = rf[ra[i*AW +: AW]];
            rd_busy[i]             = busy[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned j = 0; j < NWR; j++) begin
               if (we[j] && (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
                  rd[i*DATA_W +: DATA_W] = wd[j*DATA_W +: DATA_W];
                  rd_busy[i]             = 1'b0;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_mp_regfile.sv
module tb_mp_regfile;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   // default configuration: NREG=32, NRD=4, NWR=2
   logic [4*AW-1:0] ra;
   logic [4*DW-1:0] rd;
   logic [3:0]      rd_busy;
   logic [1:0]      we;
   logic [2*AW-1:0] wa;
   logic [2*DW-1:0] wd;
   logic [1:0]      iss_en;
   logic [2*AW-1:0] iss_addr;
   logic [5:0]      busy_cnt;

   // regression configuration: NREG=24, NRD=6, NWR=3
   logic [6*AW-1:0] r_ra;
   logic [6*DW-1:0] r_rd;
   logic [5:0]      r_rd_busy;
   logic [2:0]      r_we;
   logic [3*AW-1:0] r_wa;
   logic [3*DW-1:0] r_wd;
   logic [2:0]      r_iss_en;
   logic [3*AW-1:0] r_iss_addr;
   logic [5:0]      r_busy_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   mp_regfile dut (
      .clk(clk), .resetn(resetn), .ra(ra), .rd(rd), .rd_busy(rd_busy),
      .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
      .busy_cnt(busy_cnt)
   );

   mp_regfile #(.DATA_W(32), .NREG(24), .NRD(6), .NWR(3), .ZERO_R0(1)) dut2 (
      .clk(clk), .resetn(resetn), .ra(r_ra), .rd(r_rd), .rd_busy(r_rd_busy),
      .we(r_we), .wa(r_wa), .wd(r_wd), .iss_en(r_iss_en), .iss_addr(r_iss_addr),
      .busy_cnt(r_busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic idle();
      we = '0; wa = '0; wd = '0; iss_en = '0; iss_addr = '0;
   endtask

   task automatic r_idle();
      r_we = '0; r_wa = '0; r_wd = '0; r_iss_en = '0; r_iss_addr = '0; r_ra = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle();
      #3;
      for (int a = 0; a < 32; a += 4) begin
         for (int p = 0; p < 4; p++) ra[p*AW +: AW] = 5'(a + p);
         #1;
         for (int p = 0; p < 4; p++) begin
            n_tests++;
            if (rd[p*DW +: DW] !== 32'h0 || rd_busy[p] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_read addr=%0d rd=%h busy=%b expected rd=0 busy=0",
                        a + p, rd[p*DW +: DW], rd_busy[p]);
            end
         end
      end
      n_tests++;
      if (busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_busy_cnt got=%0d expected=0", busy_cnt);
      end
      resetn = 1'b1;
      ra = '0;
      step();
   endtask

   task automatic test_collision();
      logic [31:0] exp_same;
      we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h22, 32'h11};
      ra[0 +: AW] = 5'd5;
      #2;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'h22;
`else
      exp_same = 32'h0;
`endif
      n_tests++;
      if (rd[31:0] !== exp_same) begin
         n_fail++;
         $display("FAIL collision_same_cycle got=%h expected=%h", rd[31:0], exp_same);
      end
      step(); idle(); #1;
      n_tests++;
      if (rd[31:0] !== 32'h22) begin
         n_fail++;
         $display("FAIL collision_winner got=%h expected=00000022", rd[31:0]);
      end
      we = 2'b11; wa = {5'd9, 5'd6}; wd = {32'h44, 32'h33};
      step(); idle();
      ra[1*AW +: AW] = 5'd6; ra[2*AW +: AW] = 5'd9;
      #1;
      n_tests++;
      if (rd[63:32] !== 32'h33) begin
         n_fail++;
         $display("FAIL dual_write_p0 got=%h expected=00000033", rd[63:32]);
      end
      n_tests++;
      if (rd[95:64] !== 32'h44) begin
         n_fail++;
         $display("FAIL dual_write_p1 got=%h expected=00000044", rd[95:64]);
      end
      n_tests++;
      if (rd[31:0] !== 32'h22) begin
         n_fail++;
         $display("FAIL r5_retained got=%h expected=00000022", rd[31:0]);
      end
   endtask

   task automatic test_zero_reg();
      we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hDEAD};
      ra[0 +: AW] = 5'd0;
      step(); idle(); #1;
      n_tests++;
      if (rd[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_reg rd=%h busy=%b expected rd=0 busy=0", rd[31:0], rd_busy[0]);
      end
      n_tests++;
      if (busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL zero_reg_cnt got=%0d expected=0", busy_cnt);
      end
   endtask

   task automatic test_scoreboard();
      logic exp_b;
      iss_en = 2'b01; iss_addr = {5'd0, 5'd7};
      ra[0 +: AW] = 5'd7;
      step(); idle(); #1;
      n_tests++;
      if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
         n_fail++;
         $display("FAIL issue_r7 busy=%b cnt=%0d expected busy=1 cnt=1", rd_busy[0], busy_cnt);
      end
      // retire and re-issue r7 in the same cycle
      we = 2'b10; wa = {5'd7, 5'd0}; wd = {32'h77, 32'h0};
      iss_en = 2'b01; iss_addr = {5'd0, 5'd7};
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_b = 1'b0;
`else
      exp_b = 1'b1;
`endif
      n_tests++;
      if (rd_busy[0] !== exp_b) begin
         n_fail++;
         $display("FAIL busy_same_cycle got=%b expected=%b", rd_busy[0], exp_b);
      end
      step(); idle(); #1;
      n_tests++;
      if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1 || rd[31:0] !== 32'h77) begin
         n_fail++;
         $display("FAIL set_wins busy=%b cnt=%0d rd=%h expected busy=1 cnt=1 rd=00000077",
                  rd_busy[0], busy_cnt, rd[31:0]);
      end
      we = 2'b10; wa = {5'd7, 5'd0}; wd = {32'h78, 32'h0};
      step(); idle(); #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || rd[31:0] !== 32'h78) begin
         n_fail++;
         $display("FAIL retire_r7 busy=%b cnt=%0d rd=%h expected busy=0 cnt=0 rd=00000078",
                  rd_busy[0], busy_cnt, rd[31:0]);
      end
      iss_en = 2'b11; iss_addr = {5'd10, 5'd10};
      step(); idle(); #1;
      n_tests++;
      if (busy_cnt !== 6'd1) begin
         n_fail++;
         $display("FAIL dup_issue_cnt got=%0d expected=1", busy_cnt);
      end
      iss_en = 2'b11; iss_addr = {5'd12, 5'd11};
      step(); idle(); #1;
      n_tests++;
      if (busy_cnt !== 6'd3) begin
         n_fail++;
         $display("FAIL issue_two_cnt got=%0d expected=3", busy_cnt);
      end
      we = 2'b11; wa = {5'd11, 5'd10}; wd = {32'hB, 32'hA};
      step(); idle(); #1;
      n_tests++;
      if (busy_cnt !== 6'd1) begin
         n_fail++;
         $display("FAIL retire_two_cnt got=%0d expected=1", busy_cnt);
      end
      we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'hC};
      step(); idle(); #1;
      n_tests++;
      if (busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL retire_last_cnt got=%0d expected=0", busy_cnt);
      end
   endtask

   task automatic test_reset_mid();
      iss_en = 2'b01; iss_addr = {5'd0, 5'd3};
      step();
      iss_addr = {5'd0, 5'd4};
      step();
      iss_addr = {5'd0, 5'd5};
      step(); idle(); #1;
      n_tests++;
      if (busy_cnt !== 6'd3) begin
         n_fail++;
         $display("FAIL three_issued_cnt got=%0d expected=3", busy_cnt);
      end
      ra[0 +: AW] = 5'd5;
      #1 resetn = 1'b0;
      #1;
      n_tests++;
      if (busy_cnt !== 6'd0 || rd[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset cnt=%0d rd=%h busy=%b expected cnt=0 rd=0 busy=0",
                  busy_cnt, rd[31:0], rd_busy[0]);
      end
      // traffic presented while reset is low lands on the first edge after release
      we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'hABC};
      iss_en = 2'b10; iss_addr = {5'd12, 5'd0};
      ra[0 +: AW] = 5'd12;
      #2 resetn = 1'b1;
      step(); idle(); #1;
      n_tests++;
      if (rd[31:0] !== 32'hABC || busy_cnt !== 6'd1 || rd_busy[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL release_edge rd=%h cnt=%0d busy=%b expected rd=00000abc cnt=1 busy=1",
                  rd[31:0], busy_cnt, rd_busy[0]);
      end
      we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'hABD};
      step(); idle(); #1;
   endtask

   task automatic test_out_of_range();
      r_idle();
      r_we = 3'b011; r_wa = {5'd0, 5'd23, 5'd25}; r_wd = {32'h0, 32'h2323, 32'h2525};
      r_iss_en = 3'b100; r_iss_addr = {5'd26, 5'd0, 5'd0};
      step(); r_idle();
      r_ra[0 +: AW] = 5'd25; r_ra[1*AW +: AW] = 5'd26; r_ra[2*AW +: AW] = 5'd23;
      #1;
      n_tests++;
      if (r_rd[31:0] !== 32'h0 || r_rd[63:32] !== 32'h0 || r_rd_busy[1:0] !== 2'b00) begin
         n_fail++;
         $display("FAIL oob_read rd25=%h rd26=%h busy=%b expected 0 0 00",
                  r_rd[31:0], r_rd[63:32], r_rd_busy[1:0]);
      end
      n_tests++;
      if (r_busy_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL oob_issue_cnt got=%0d expected=0", r_busy_cnt);
      end
      n_tests++;
      if (r_rd[95:64] !== 32'h2323) begin
         n_fail++;
         $display("FAIL top_reg_write got=%h expected=00002323", r_rd[95:64]);
      end
   endtask

   function automatic logic [4:0] rand_addr();
      int s;
      s = $urandom_range(0, 9);
      if (s == 0)      rand_addr = 5'($urandom_range(24, 31));
      else if (s < 6)  rand_addr = 5'($urandom_range(0, 5));
      else             rand_addr = 5'($urandom_range(0, 23));
   endfunction

   task automatic test_random();
      logic [31:0]   m_rf [24];
      logic          m_busy [24];
      logic [6*DW-1:0] e_rd;
      logic [5:0]      e_busy;
      int              e_cnt;
      int              shown = 0;
      int              a;
      for (int k = 0; k < 24; k++) begin
         m_rf[k] = '0;
         m_busy[k] = 1'b0;
      end
      r_idle();
      #2 resetn = 1'b0;
      #2 resetn = 1'b1;
      step();
      for (int c = 0; c < 3000; c++) begin
         for (int j = 0; j < 3; j++) begin
            r_we[j] = ($urandom_range(0, 1) == 1);
            r_wa[j*AW +: AW] = rand_addr();
            r_wd[j*DW +: DW] = $urandom;
            r_iss_en[j] = ($urandom_range(0, 2) == 0);
            r_iss_addr[j*AW +: AW] = rand_addr();
         end
         for (int i = 0; i < 6; i++) r_ra[i*AW +: AW] = rand_addr();
         #2;
         for (int i = 0; i < 6; i++) begin
            a = int'(r_ra[i*AW +: AW]);
            e_rd[i*DW +: DW] = '0;
            e_busy[i] = 1'b0;
            if (a > 0 && a < 24) begin
               e_rd[i*DW +: DW] = m_rf[a];
               e_busy[i] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
               for (int j = 0; j < 3; j++) begin
                  if (r_we[j] && int'(r_wa[j*AW +: AW]) == a) begin
                     e_rd[i*DW +: DW] = r_wd[j*DW +: DW];
                     e_busy[i] = 1'b0;
                  end
               end
`endif
            end
         end
         n_tests++;
         if (r_rd !== e_rd) begin
            n_fail++;
            if (shown < 10) $display("FAIL rand_rd cycle=%0d got=%h expected=%h", c, r_rd, e_rd);
            shown++;
         end
         n_tests++;
         if (r_rd_busy !== e_busy) begin
            n_fail++;
            if (shown < 10) $display("FAIL rand_rd_busy cycle=%0d got=%b expected=%b", c, r_rd_busy, e_busy);
            shown++;
         end
         for (int j = 0; j < 3; j++) begin
            a = int'(r_wa[j*AW +: AW]);
            if (r_we[j] && a > 0 && a < 24) begin
               m_rf[a] = r_wd[j*DW +: DW];
               m_busy[a] = 1'b0;
            end
         end
         for (int j = 0; j < 3; j++) begin
            a = int'(r_iss_addr[j*AW +: AW]);
            if (r_iss_en[j] && a > 0 && a < 24) m_busy[a] = 1'b1;
         end
         e_cnt = 0;
         for (int k = 0; k < 24; k++) if (m_busy[k]) e_cnt++;
         step();
         n_tests++;
         if (int'(r_busy_cnt) != e_cnt) begin
            n_fail++;
            if (shown < 10) $display("FAIL rand_busy_cnt cycle=%0d got=%0d expected=%0d", c, r_busy_cnt, e_cnt);
            shown++;
         end
      end
      r_idle();
   endtask

   initial begin
      ra = '0;
      idle();
      r_idle();
      test_reset();
      test_collision();
      test_zero_reg();
      test_scoreboard();
      test_reset_mid();
      test_out_of_range();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
